tsu_queue_merge: RTL and testbench

//  Drains the timestamp-queue read ports of NCH tsu instances, e.g. RX and TX per port,
//  in round-robin order and merges them into one tagged output FIFO.

---
 rtl/tsu_queue_merge.sv | 168 ++++++++++++++++
 tb/tb_tsu_queue_merge.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsu_queue_merge.sv
// Round-robin drain of NCH tsu timestamp-queue read ports into one tagged show-ahead FIFO.
// Optional per-channel push counters are compiled in when TSU_MERGE_CNT_EN is defined.
module tsu_queue_merge #(
  parameter  int NCH   = 2,
  parameter  int DW    = 128,
  parameter  int SW    = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              q_rd_clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    ch_mask,
  output logic [NCH-1:0]    ch_q_rd_en,
  input  logic [NCH*SW-1:0] ch_q_rd_stat,
  input  logic [NCH*DW-1:0] ch_q_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  output logic [CW-1:0]     m_chan,
  output logic [AW:0]       m_level
`ifdef TSU_MERGE_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [NCH*16-1:0] ch_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RD, CAP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    grant, grant_d;
  logic [CW-1:0]    rr_ptr;
  logic             bo_vld;
  logic [CW-1:0]    bo_ch;
  logic [NCH-1:0]   elig;
  logic             any_elig;
  logic [CW-1:0]    pick;
  logic             room;
  logic             push, pop;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [DW-1:0]    cap_data;
  logic [CW+DW-1:0] head;
  logic [CW+DW-1:0] ram [DEPTH];

  function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] c);
    if (int'(c) >= NCH - 1) return '0;
    return c + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      elig[i] = ch_mask[i] && (ch_q_rd_stat[i*SW +: SW] != '0) &&
                !(bo_vld && (bo_ch == CW'(i)));
    end
  end

  // Walk downward so the last hit is the first eligible channel at or after rr_ptr.
  always_comb begin
    int idx;
    idx      = 0;
    any_elig = 1'b0;
    pick     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (elig[idx]) begin
        any_elig = 1'b1;
        pick     = CW'(idx);
      end
    end
  end

  assign room = (m_level < (AW+1)'(DEPTH));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant;
    ch_q_rd_en = '0;
    unique case (state_q)
      IDLE: begin
        if (any_elig && room) begin
          state_d = RD;
          grant_d = pick;
        end
      end
      RD: begin
        ch_q_rd_en[grant] = 1'b1;
        state_d           = CAP;
      end
      CAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == CW'(i)) cap_data = ch_q_rd_data[i*DW +: DW];
    end
  end

  assign push = (state_q == CAP);
  assign pop  = m_valid && m_ready;

  // Control stage: FSM, arbitration pointer, blackout and FIFO bookkeeping.
  always_ff @(posedge q_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      bo_vld  <= 1'b0;
      bo_ch   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      m_level <= '0;
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      if (state_q == RD) rr_ptr <= next_ch(grant);
      // The blackout masks the just-read channel while its tsu status catches up.
      if (state_q == CAP) begin
        bo_vld <= 1'b1;
        bo_ch  <= grant;
      end else if (state_q == IDLE) begin
        bo_vld <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   m_level <= m_level + (AW+1)'(1);
        2'b01:   m_level <= m_level - (AW+1)'(1);
        default: m_level <= m_level;
      endcase
    end
  end

  // Capture stage: tagged entry written one cycle after the read strobe.
  always_ff @(posedge q_rd_clk) begin
    if (push) ram[wr_ptr] <= {grant, cap_data};
  end

  assign head    = ram[rd_ptr];
  assign m_valid = (m_level != '0);
  assign m_data  = m_valid ? head[DW-1:0] : '0;
  assign m_chan  = m_valid ? head[CW+DW-1:DW] : '0;

`ifdef TSU_MERGE_CNT_EN
  logic [15:0] cnt [NCH];

  always_ff @(posedge q_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cnt_clr)
          cnt[i] <= '0;
        else if (push && (grant == CW'(i)) && (cnt[i] != 16'hFFFF))
          cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) ch_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_tsu_queue_merge.sv
// Bench for tsu_queue_merge: table-driven scenarios, corner sequences and a randomized
// run scored against a queue-level model of the tsu queues and the merged output stream.
module tb_tsu_queue_merge;
  localparam int NCH = 2, DW = 128, SW = 8, DEPTH = 16, CW = 1, AW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    ch_mask = '0;
  logic [NCH-1:0]    ch_q_rd_en;
  logic [NCH*SW-1:0] ch_q_rd_stat = '0;
  logic [NCH*DW-1:0] ch_q_rd_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DW-1:0]     m_data;
  logic [CW-1:0]     m_chan;
  logic [AW:0]       m_level;
`ifdef TSU_MERGE_CNT_EN
  logic              cnt_clr = 1'b0;
  logic [NCH*16-1:0] ch_cnt;
`endif

  always #5 clk = ~clk;

  tsu_queue_merge #(.NCH(NCH), .DW(DW), .SW(SW), .DEPTH(DEPTH)) dut (
    .q_rd_clk(clk), .rst_n(rst_n), .ch_mask(ch_mask), .ch_q_rd_en(ch_q_rd_en),
    .ch_q_rd_stat(ch_q_rd_stat), .ch_q_rd_data(ch_q_rd_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan), .m_level(m_level)
`ifdef TSU_MERGE_CNT_EN
    , .cnt_clr(cnt_clr), .ch_cnt(ch_cnt)
`endif
  );

  typedef struct { int ch; logic [DW-1:0] d; } ent_t;

  logic [DW-1:0] tq [NCH][$];
  ent_t          exp_q [$];
  int            ovr [NCH];
  int            n_chk = 0, n_err = 0;
  int            cyc = 0;
  bit            pend_vld = 0;
  int            pend_ch = 0;
  logic [DW-1:0] pend_d;
  logic [NCH-1:0] prev_mask = '0;
  logic [NCH-1:0] prev_nz = '0;
  int            prev_level = 0;
  int            last_any = -100;
  int            last_ch [NCH];
  int            str_cnt [NCH];
  int            grant_log [$];
  int            str_t [$];
  int            pop_log [$];

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue-level model: tsu queues feed strobes, every strobe yields one tagged entry in order.
  always @(negedge clk) begin
    ent_t e;
    int   s;
    if (!rst_n) begin
      pend_vld = 0;
      exp_q.delete();
      last_any = -100;
      for (int i = 0; i < NCH; i++) last_ch[i] = -100;
    end else begin
      chk("level", int'(m_level), exp_q.size());
      if (!m_valid) begin
        chk_d("idle_data", m_data, '0);
        chk("idle_chan", int'(m_chan), 0);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("pop_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pop_chan", int'(m_chan), e.ch);
          chk_d("pop_data", m_data, e.d);
          pop_log.push_back(int'(m_chan));
        end
      end
      if (pend_vld) begin
        ch_q_rd_data[pend_ch*DW +: DW] = pend_d;
        exp_q.push_back('{ch: pend_ch, d: pend_d});
        pend_vld = 0;
      end
      if (ch_q_rd_en != '0) begin
        chk("strobe_onehot", $countones(ch_q_rd_en), 1);
        for (int i = 0; i < NCH; i++) begin
          if (ch_q_rd_en[i]) begin
            chk("strobe_masked", int'(prev_mask[i]), 1);
            chk("strobe_stat", int'(prev_nz[i]), 1);
            chk("strobe_room", int'(prev_level < DEPTH), 1);
            chk("gap_any", int'((cyc - last_any) >= 3), 1);
            chk("gap_same_ch", int'((cyc - last_ch[i]) >= 4), 1);
            last_any = cyc;
            last_ch[i] = cyc;
            str_cnt[i]++;
            grant_log.push_back(i);
            str_t.push_back(cyc);
            pend_vld = 1;
            pend_ch = i;
            pend_d = (tq[i].size() > 0) ? tq[i].pop_front() : rnd();
            ch_q_rd_data[i*DW +: DW] = rnd();
          end
        end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      s = (ovr[i] >= 0) ? ovr[i] : ((tq[i].size() > 255) ? 255 : tq[i].size());
      ch_q_rd_stat[i*SW +: SW] = SW'(s);
      prev_nz[i] = (s != 0);
    end
    prev_mask = ch_mask;
    prev_level = int'(m_level);
    cyc++;
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rd_en", int'(ch_q_rd_en), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_level", int'(m_level), 0);
    chk_d("rst_data", m_data, '0);
    chk("rst_chan", int'(m_chan), 0);
    for (int i = 0; i < NCH; i++) begin
      tq[i].delete();
      ovr[i] = -1;
      str_cnt[i] = 0;
    end
    grant_log.delete();
    str_t.delete();
    pop_log.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en_edge", int'(ch_q_rd_en), 0);
    chk("rst_level_edge", int'(m_level), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_strobe(input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #2;
      if (ch_q_rd_en != '0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_strobe_timeout", 0, 1);
  endtask

  typedef struct {
    logic [1:0] mask; int n0; int n1; bit rdy; int e0; int e1; int elvl;
  } vec_t;

  initial begin
    vec_t vt [7];
    bit   ok;
    int   n;
    for (int i = 0; i < NCH; i++) begin
      ovr[i] = -1;
      last_ch[i] = -100;
      str_cnt[i] = 0;
    end
    vt[0] = '{2'b11,  3,  3, 1'b1,  3, 3,  0};
    vt[1] = '{2'b10,  3,  3, 1'b1,  0, 3,  0};
    vt[2] = '{2'b01,  3,  3, 1'b1,  3, 0,  0};
    vt[3] = '{2'b00,  3,  3, 1'b1,  0, 0,  0};
    vt[4] = '{2'b11, 20,  0, 1'b0, 16, 0, 16};
    vt[5] = '{2'b11, 10, 10, 1'b0,  8, 8, 16};
    vt[6] = '{2'b11,  0,  5, 1'b1,  0, 5,  0};
    @(posedge clk);
    #2;

    for (int v = 0; v < 7; v++) begin
      do_reset();
      ch_mask = vt[v].mask;
      m_ready = vt[v].rdy;
      for (int k = 0; k < vt[v].n0; k++) tq[0].push_back(rnd());
      for (int k = 0; k < vt[v].n1; k++) tq[1].push_back(rnd());
      run(150);
      chk($sformatf("vec%0d_ch0_reads", v), str_cnt[0], vt[v].e0);
      chk($sformatf("vec%0d_ch1_reads", v), str_cnt[1], vt[v].e1);
      chk($sformatf("vec%0d_level", v), int'(m_level), vt[v].elvl);
    end

    // Alternating grant order and matching tags at the output.
    do_reset();
    ch_mask = 2'b11;
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tq[0].push_back(rnd());
      tq[1].push_back(rnd());
    end
    run(40);
    chk("rr_grant_count", grant_log.size(), 6);
    chk("rr_pop_count", pop_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) chk("rr_grant_order", grant_log[k], k % 2);
    for (int k = 0; k < 6 && k < pop_log.size(); k++) chk("rr_chan_order", pop_log[k], k % 2);

    // Full FIFO stalls reads; a single pop admits exactly one more.
    do_reset();
    ch_mask = 2'b01;
    m_ready = 1'b0;
    for (int k = 0; k < 20; k++) tq[0].push_back(rnd());
    run(100);
    chk("full_reads", str_cnt[0], 16);
    chk("full_level", int'(m_level), 16);
    m_ready = 1'b1;
    run(1);
    m_ready = 1'b0;
    run(30);
    chk("pop_one_reads", str_cnt[0], 17);
    chk("pop_one_level", int'(m_level), 16);

    // Stuck status: blackout spaces ch0 reads, and ch1 fills the blackout slot.
    do_reset();
    ch_mask = 2'b11;
    m_ready = 1'b1;
    ovr[0] = 1;
    ovr[1] = 0;
    run(40);
    n = str_t.size();
    chk("stuck_reads_seen", int'(n >= 4), 1);
    for (int k = (n >= 4) ? n - 3 : n; k < n; k++) begin
      chk("stuck_gap_ch0", str_t[k] - str_t[k-1], 4);
      chk("stuck_ch0_only", grant_log[k], 0);
    end
    ovr[1] = 1;
    grant_log.delete();
    str_t.delete();
    run(40);
    n = str_t.size();
    chk("alt_reads_seen", int'(n >= 5), 1);
    for (int k = (n >= 5) ? n - 4 : n; k < n; k++) begin
      chk("alt_gap", str_t[k] - str_t[k-1], 3);
      chk("alt_channel_switch", int'(grant_log[k] != grant_log[k-1]), 1);
    end

    // Mask removed while a read is in flight: the entry still lands.
    do_reset();
    ch_mask = 2'b10;
    m_ready = 1'b0;
    tq[0].push_back(rnd());
    tq[1].push_back(rnd());
    wait_strobe(20, ok);
    chk("mask_mid_strobe_ch1", int'(ch_q_rd_en), 2);
    ch_mask = 2'b00;
    run(10);
    chk("mask_mid_level", int'(m_level), 1);
    chk("mask_mid_chan", int'(m_chan), 1);
    chk("mask_mid_ch0_reads", str_cnt[0], 0);

    // Reset asserted during a read strobe.
    do_reset();
    ch_mask = 2'b11;
    m_ready = 1'b1;
    tq[0].push_back(rnd());
    tq[0].push_back(rnd());
    wait_strobe(20, ok);
    do_reset();

`ifdef TSU_MERGE_CNT_EN
    ch_mask = 2'b01;
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) tq[0].push_back(rnd());
    run(40);
    chk("cnt_ch0", int'(ch_cnt[15:0]), 5);
    chk("cnt_ch1", int'(ch_cnt[31:16]), 0);
    tq[0].push_back(rnd());
    wait_strobe(20, ok);
    run(1);
    cnt_clr = 1'b1;
    run(1);
    cnt_clr = 1'b0;
    chk("cnt_clr_wins", int'(ch_cnt[15:0]), 0);
`endif

    // Randomized traffic, mask churn and back-pressure.
    do_reset();
    ch_mask = 2'b11;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(7) == 0) ch_mask = NCH'($urandom);
      m_ready = ($urandom_range(9) < 6);
      if ($urandom_range(4) == 0) tq[$urandom_range(NCH-1)].push_back(rnd());
      run(1);
    end
    ch_mask = 2'b11;
    m_ready = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      if (tq[0].size() == 0 && tq[1].size() == 0 && exp_q.size() == 0 && !pend_vld && m_level == '0)
        break;
      run(1);
    end
    run(10);
    chk("drain_ch0_queue", tq[0].size(), 0);
    chk("drain_ch1_queue", tq[1].size(), 0);
    chk("drain_expected", exp_q.size(), 0);
    chk("drain_level", int'(m_level), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
